// File: rtl/mem_access_ctrl.sv
// Memory bus initiator for the multicycle CPU: arbitrates instruction fetch and data
// load/store onto one 16-bit word memory, one access per IDLE->ACCESS->RESP pass.
module mem_access_ctrl #(
   parameter int DEPTH_WORDS  = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   output logic [15:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_ack,
   output logic [15:0] d_rdata,
   output logic        d_err,
   output logic        mem_we,
   output logic [15:0] mem_a,
   output logic [15:0] mem_wd,
   input  logic [15:0] mem_rd
);

   localparam int            CW       = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
   localparam logic [16:0]   ADDR_END = 17'(2 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_grant;
   logic           w_grant_fetch;
   logic [15:0]    w_addr;
   logic           w_mem_we;

   logic           r_gnt_fetch;
   logic           r_we;
   logic           r_illegal;
   logic [CW-1:0]  r_starve;
   logic [15:0]    r_mem_a;
   logic [15:0]    r_mem_wd;
   logic [15:0]    r_if_rdata;
   logic [15:0]    r_d_rdata;
   logic           r_if_ack;
   logic           r_if_err;
   logic           r_d_ack;
   logic           r_d_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_grant       = 1'b0;
      w_grant_fetch = 1'b0;
      w_addr        = d_addr;
      w_mem_we      = 1'b0;
      case (r_state)
         IDLE: begin
            if (if_req || d_req) begin
               w_grant       = 1'b1;
               // data has priority unless fetch has been starved long enough
               w_grant_fetch = if_req && (!d_req || (r_starve == LIMIT));
               w_addr        = w_grant_fetch ? if_addr : d_addr;
               w_state_nxt   = ACCESS;
            end
         end
         ACCESS: begin
            w_mem_we    = !r_gnt_fetch && r_we && !r_illegal;
            w_state_nxt = RESP;
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt_fetch <= 1'b0;
         r_we        <= 1'b0;
         r_illegal   <= 1'b0;
         r_starve    <= '0;
         r_mem_a     <= '0;
         r_mem_wd    <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_if_ack    <= 1'b0;
         r_if_err    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_d_err     <= 1'b0;
      end else begin
         r_if_ack <= 1'b0;
         r_if_err <= 1'b0;
         r_d_ack  <= 1'b0;
         r_d_err  <= 1'b0;
         if (w_grant) begin
            r_gnt_fetch <= w_grant_fetch;
            r_we        <= d_we & ~w_grant_fetch;
            r_illegal   <= w_addr[0] | ({1'b0, w_addr} >= ADDR_END);
            r_mem_a     <= w_addr;
            if (!w_grant_fetch) r_mem_wd <= d_wdata;
            if (w_grant_fetch || !if_req) r_starve <= '0;
            else if (r_starve != LIMIT)   r_starve <= r_starve + 1'b1;
         end
         // acks are registered at the end of ACCESS so they are high exactly during RESP
         if (r_state == ACCESS) begin
            if (!r_illegal) begin
               if (r_gnt_fetch)  r_if_rdata <= mem_rd;
               else if (!r_we)   r_d_rdata  <= mem_rd;
            end
            r_if_ack <= r_gnt_fetch;
            r_if_err <= r_gnt_fetch & r_illegal;
            r_d_ack  <= ~r_gnt_fetch;
            r_d_err  <= ~r_gnt_fetch & r_illegal;
         end
      end
   end

   assign mem_we   = w_mem_we;
   assign mem_a    = r_mem_a;
   assign mem_wd   = r_mem_wd;
   assign if_ack   = r_if_ack;
   assign if_err   = r_if_err;
   assign if_rdata = r_if_rdata;
   assign d_ack    = r_d_ack;
   assign d_err    = r_d_err;
   assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed steps plus randomized fetch/load/store traffic
// checked against a word-array reference model of the attached memory.
module tb_mem_access_ctrl;
   localparam int DEPTH = 64;
   localparam int AW    = $clog2(DEPTH);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        if_ack;
   logic [15:0] if_rdata;
   logic        if_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        d_err;
   logic        mem_we;
   logic [15:0] mem_a;
   logic [15:0] mem_wd;
   logic [15:0] mem_rd;

   logic [15:0] tb_mem  [DEPTH];
   logic [15:0] ref_mem [DEPTH];
   logic [15:0] exp_if_rdata = '0;
   logic [15:0] exp_d_rdata  = '0;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // attached memory: combinational read, synchronous write
   assign mem_rd = tb_mem[mem_a[AW:1]];
   always @(posedge clk) if (mem_we) tb_mem[mem_a[AW:1]] = mem_wd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [15:0] a);
      return (a[0] == 1'b0) && ({16'b0, a} < 32'(2 * DEPTH));
   endfunction

   task automatic f_txn(input logic [15:0] addr);
      int cyc = 0, we_seen = 0, stray = 0;
      bit ex_err = !legal(addr);
      if (!ex_err) exp_if_rdata = ref_mem[addr[AW:1]];
      @(negedge clk);
      if_req = 1'b1; if_addr = addr;
      do begin
         @(negedge clk); cyc++;
         if (mem_we) we_seen++;
         if (d_ack || d_err || (!if_ack && if_err)) stray++;
      end while (!if_ack && cyc < 10);
      if_req = 1'b0;
      chk("f_latency", cyc, 2);
      chk("f_err", if_err, ex_err);
      chk("f_rdata", if_rdata, exp_if_rdata);
      chk("f_no_write", we_seen, 0);
      chk("f_stray", stray, 0);
   endtask

   task automatic d_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      int cyc = 0, we_seen = 0, stray = 0;
      bit ex_err = !legal(addr);
      if (!ex_err) begin
         if (we) ref_mem[addr[AW:1]] = wdata;
         else    exp_d_rdata = ref_mem[addr[AW:1]];
      end
      @(negedge clk);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      do begin
         @(negedge clk); cyc++;
         if (mem_we) begin
            we_seen++;
            chk("d_mem_a", mem_a, addr);
            chk("d_mem_wd", mem_wd, wdata);
         end
         if (if_ack || if_err || (!d_ack && d_err)) stray++;
      end while (!d_ack && cyc < 10);
      d_req = 1'b0;
      chk("d_latency", cyc, 2);
      chk("d_err", d_err, ex_err);
      chk("d_rdata", d_rdata, exp_d_rdata);
      chk("d_write_count", we_seen, (we && !ex_err) ? 1 : 0);
      chk("d_stray", stray, 0);
   endtask

   initial begin
      logic [9:0]  seq;
      logic [4:0]  ackv;
      logic [15:0] first_exp, second_exp;
      int n, cyc, last, badgap, both, stray, mism;

      for (int i = 0; i < DEPTH; i++) begin
         tb_mem[i]  = 16'($urandom);
         ref_mem[i] = tb_mem[i];
      end
      tb_mem[0]  = 16'h2002;
      ref_mem[0] = 16'h2002;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_if_ack", if_ack, 0);   chk("rst_if_err", if_err, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_ack", d_ack, 0);     chk("rst_d_err", d_err, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_we", mem_we, 0);   chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_wd", mem_wd, 0);
      rst_n = 1'b1;

      // fetch of word 0
      f_txn(16'h0000);
      chk("fetch_word0", if_rdata, 16'h2002);

      // store then load back
      d_txn(1'b1, 16'h0010, 16'hBEEF);
      d_txn(1'b0, 16'h0010, 16'h0000);
      chk("load_beef", d_rdata, 16'hBEEF);

      // misaligned load and out-of-range store
      d_txn(1'b0, 16'h0003, 16'h0000);
      d_txn(1'b1, 16'h0080, 16'h5A5A);
      chk("oor_rdata_held", d_rdata, 16'hBEEF);

      // both clients held: starvation forces every fifth grant to fetch
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0000;
      d_req = 1'b1;  d_we = 1'b0; d_addr = 16'h0010;
      seq = '0; n = 0; cyc = 0; last = -1; badgap = 0; both = 0;
      while (n < 10 && cyc < 60) begin
         @(negedge clk); cyc++;
         if (d_ack && if_ack) both++;
         if (d_ack || if_ack) begin
            seq = {seq[8:0], if_ack};
            if (last >= 0 && cyc - last != 3) badgap++;
            last = cyc; n++;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("arb_count", n, 10);
      chk("arb_order", seq, 10'b0000100001);
      chk("arb_both", both, 0);
      chk("arb_spacing", badgap, 0);
      chk("arb_if_rdata", if_rdata, 16'h2002);
      chk("arb_d_rdata", d_rdata, 16'hBEEF);

      // reset during the ACCESS cycle of a store
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
      @(posedge clk); #2;
      chk("abort_we_active", mem_we, 1);
      rst_n = 1'b0; #1;
      chk("abort_we_drop", mem_we, 0);
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0;
      stray = 0;
      repeat (2) begin @(negedge clk); if (d_ack || if_ack) stray++; end
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (d_ack || if_ack) stray++; end
      chk("abort_no_ack", stray, 0);
      chk("abort_mem", tb_mem[16], ref_mem[16]);
      exp_d_rdata = '0; exp_if_rdata = '0;
      chk("abort_rdata_cleared", d_rdata, 0);
      d_txn(1'b0, 16'h0020, 16'h0000);

      // back-to-back data request with address changed after the first grant
      first_exp  = ref_mem[8];
      second_exp = ref_mem[2];
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      ackv = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         ackv = {ackv[3:0], d_ack};
         if (c == 1) begin chk("b2b_mem_a1", mem_a, 16'h0010); d_addr = 16'h0004; end
         if (c == 2) chk("b2b_rdata1", d_rdata, first_exp);
         if (c == 4) chk("b2b_mem_a2", mem_a, 16'h0004);
         if (c == 5) chk("b2b_rdata2", d_rdata, second_exp);
      end
      d_req = 1'b0;
      chk("b2b_acks", ackv, 5'b01001);
      exp_d_rdata = second_exp;

      // randomized single-client traffic
      for (int k = 0; k < 40; k++) begin
         logic [15:0] a;
         a = (k % 8 == 7) ? 16'($urandom) : 16'($urandom_range(0, 2 * DEPTH + 15));
         if ($urandom_range(0, 2) == 0) f_txn(a);
         else d_txn(1'($urandom_range(0, 1)), a, 16'($urandom));
      end
      repeat (2) @(negedge clk);
      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
      chk("final_memory", mism, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
